// File: rtl/window_pkg.sv
// Shared definitions for the window row sequencer: FSM state encoding and
// default parameter values used by window_row_seq.
package window_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefBitwidthRow    = 4;
  localparam int unsigned DefBitwidthIfRows = 10;
  localparam int unsigned DefBitwidthStride = 4;
  localparam int unsigned DefNumCh          = 3;

endpackage

// File: rtl/stride_acc.sv
// Stride accumulator: holds the base row of the current window.
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low clear
//   en_i     - add stride_i to the accumulator this cycle
//   clr_i    - synchronous load of zero (has priority over en_i)
//   stride_i - step added on each enabled cycle
//   acc_o    - accumulator value (wraps modulo 2^AccWidth)
module stride_acc #(
  parameter int unsigned AccWidth    = 10,
  parameter int unsigned StrideWidth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [StrideWidth-1:0] stride_i,
  output logic [AccWidth-1:0]    acc_o
);

  logic [AccWidth-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AccWidth'(stride_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/window_row_seq.sv
// Window row sequencer: after Start, presents a sequence of convolution
// windows, each as K parallel row indices (base + Offset + i). The base
// advances by Stride on every accepted window until the window whose
// successor would run past IF_Rows has been accepted.
//   WINDOW_ROW_SEQ_clk/Clr       - clock / async active-low reset
//   Start, Stride, Offset,
//   Kernel_Rows, IF_Rows         - job request and configuration (latched on Start)
//   Ready                        - downstream accepts the presented window
//   Row, Row_En, Valid, Last     - presented window
//   Busy, Done, Win_Count        - job status
module window_row_seq
  import window_pkg::*;
#(
  parameter int unsigned BITWIDTH_ROW     = DefBitwidthRow,
  parameter int unsigned BITWIDTH_IF_ROWS = DefBitwidthIfRows,
  parameter int unsigned BITWIDTH_STRIDE  = DefBitwidthStride,
  parameter int unsigned NUM_CH           = DefNumCh
) (
  input  logic                               WINDOW_ROW_SEQ_clk,
  input  logic                               WINDOW_ROW_SEQ_Clr,
  input  logic                               WINDOW_ROW_SEQ_Start,
  input  logic [BITWIDTH_STRIDE-1:0]         WINDOW_ROW_SEQ_Stride,
  input  logic [BITWIDTH_ROW-1:0]            WINDOW_ROW_SEQ_Offset,
  input  logic [BITWIDTH_ROW-1:0]            WINDOW_ROW_SEQ_Kernel_Rows,
  input  logic [BITWIDTH_IF_ROWS-1:0]        WINDOW_ROW_SEQ_IF_Rows,
  input  logic                               WINDOW_ROW_SEQ_Ready,
  output logic [NUM_CH*BITWIDTH_IF_ROWS-1:0] WINDOW_ROW_SEQ_Row,
  output logic [NUM_CH-1:0]                  WINDOW_ROW_SEQ_Row_En,
  output logic                               WINDOW_ROW_SEQ_Valid,
  output logic                               WINDOW_ROW_SEQ_Last,
  output logic                               WINDOW_ROW_SEQ_Busy,
  output logic                               WINDOW_ROW_SEQ_Done,
  output logic [BITWIDTH_IF_ROWS-1:0]        WINDOW_ROW_SEQ_Win_Count
);

  localparam int unsigned W = BITWIDTH_IF_ROWS;

  state_e                     state_d, state_q;
  logic [BITWIDTH_STRIDE-1:0] stride_d, stride_q;
  logic [BITWIDTH_ROW-1:0]    offset_d, offset_q;
  logic [BITWIDTH_ROW-1:0]    k_d, k_q;
  logic [W-1:0]               if_rows_d, if_rows_q;
  logic [W-1:0]               count_d, count_q;
  logic [W-1:0]               base;

  logic                       start_go;
  logic                       valid;
  logic                       accept;
  logic                       last;
  logic                       skip;
  logic [BITWIDTH_ROW-1:0]    k_raw;
  logic [BITWIDTH_ROW-1:0]    k_clamp;
  logic [BITWIDTH_STRIDE-1:0] stride_norm;
  logic [W:0]                 last_sum;

  stride_acc #(
    .AccWidth    (W),
    .StrideWidth (BITWIDTH_STRIDE)
  ) u_base_acc (
    .clk_i    (WINDOW_ROW_SEQ_clk),
    .rst_ni   (WINDOW_ROW_SEQ_Clr),
    .en_i     (accept),
    .clr_i    (start_go),
    .stride_i (stride_q),
    .acc_o    (base)
  );

  always_comb begin
    start_go    = (state_q == StIdle) && WINDOW_ROW_SEQ_Start;
    k_raw       = (WINDOW_ROW_SEQ_Kernel_Rows == '0) ? BITWIDTH_ROW'(1)
                                                     : WINDOW_ROW_SEQ_Kernel_Rows;
    k_clamp     = (32'(k_raw) > NUM_CH) ? BITWIDTH_ROW'(NUM_CH) : k_raw;
    stride_norm = (WINDOW_ROW_SEQ_Stride == '0) ? BITWIDTH_STRIDE'(1) : WINDOW_ROW_SEQ_Stride;
    // The empty-job test uses the requested K before clamping to NUM_CH.
    skip        = 32'(k_raw) > 32'(WINDOW_ROW_SEQ_IF_Rows);
    valid       = (state_q == StRun);
    accept      = valid && WINDOW_ROW_SEQ_Ready;
    // One extra bit so the end-of-map comparison never wraps.
    last_sum    = {1'b0, base} + (W + 1)'(stride_q) + (W + 1)'(k_q);
    last        = valid && (last_sum > {1'b0, if_rows_q});
  end

  always_comb begin
    state_d   = state_q;
    stride_d  = stride_q;
    offset_d  = offset_q;
    k_d       = k_q;
    if_rows_d = if_rows_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        if (start_go) begin
          stride_d  = stride_norm;
          offset_d  = WINDOW_ROW_SEQ_Offset;
          k_d       = k_clamp;
          if_rows_d = WINDOW_ROW_SEQ_IF_Rows;
          count_d   = '0;
          state_d   = skip ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          count_d = count_q + W'(1);
          if (last) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge WINDOW_ROW_SEQ_clk or negedge WINDOW_ROW_SEQ_Clr) begin
    if (!WINDOW_ROW_SEQ_Clr) begin
      state_q   <= StIdle;
      stride_q  <= '0;
      offset_q  <= '0;
      k_q       <= '0;
      if_rows_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      stride_q  <= stride_d;
      offset_q  <= offset_d;
      k_q       <= k_d;
      if_rows_q <= if_rows_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    WINDOW_ROW_SEQ_Row    = '0;
    WINDOW_ROW_SEQ_Row_En = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      WINDOW_ROW_SEQ_Row[i*W +: W] = base + W'(offset_q) + W'(i);
      WINDOW_ROW_SEQ_Row_En[i]     = valid && (i < 32'(k_q));
    end
  end

  assign WINDOW_ROW_SEQ_Valid     = valid;
  assign WINDOW_ROW_SEQ_Last      = last;
  assign WINDOW_ROW_SEQ_Busy      = (state_q != StIdle);
  assign WINDOW_ROW_SEQ_Done      = (state_q == StDone);
  assign WINDOW_ROW_SEQ_Win_Count = count_q;

endmodule

// File: tb/tb_window_row_seq.sv
// Self-checking bench for window_row_seq: a job-level reference model
// (window count from a closed-form expression, base = index * stride)
// checked against the DUT on every falling edge, plus literal expectations
// for the directed scenarios.
module tb_window_row_seq;

  localparam int W      = 10;
  localparam int NUM_CH = 3;
  localparam int PhIdle = 0;
  localparam int PhRun  = 1;
  localparam int PhDone = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        stride = '0;
  logic [3:0]        offset = '0;
  logic [3:0]        krows = '0;
  logic [W-1:0]      if_rows = '0;
  logic              ready = 1'b1;
  logic [NUM_CH*W-1:0] row;
  logic [NUM_CH-1:0] row_en;
  logic              valid, last, busy, done;
  logic [W-1:0]      win_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acc_q[$];
  int first_row_en = -1;

  window_row_seq dut (
    .WINDOW_ROW_SEQ_clk         (clk),
    .WINDOW_ROW_SEQ_Clr         (rst_n),
    .WINDOW_ROW_SEQ_Start       (start),
    .WINDOW_ROW_SEQ_Stride      (stride),
    .WINDOW_ROW_SEQ_Offset      (offset),
    .WINDOW_ROW_SEQ_Kernel_Rows (krows),
    .WINDOW_ROW_SEQ_IF_Rows     (if_rows),
    .WINDOW_ROW_SEQ_Ready       (ready),
    .WINDOW_ROW_SEQ_Row         (row),
    .WINDOW_ROW_SEQ_Row_En      (row_en),
    .WINDOW_ROW_SEQ_Valid       (valid),
    .WINDOW_ROW_SEQ_Last        (last),
    .WINDOW_ROW_SEQ_Busy        (busy),
    .WINDOW_ROW_SEQ_Done        (done),
    .WINDOW_ROW_SEQ_Win_Count   (win_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Number of windows a job produces, straight from the job rules.
  function automatic int num_windows(input int s, input int k, input int ifr);
    int kr, kc, se;
    kr = (k == 0) ? 1 : k;
    kc = (kr > NUM_CH) ? NUM_CH : kr;
    se = (s == 0) ? 1 : s;
    if (kr > ifr) return 0;
    return (ifr - kc) / se + 1;
  endfunction

  // Reference model: job phase, window index and accepted count.
  int m_phase = PhIdle;
  int m_n = 0, m_idx = 0, m_count = 0, m_s = 0, m_k = 0, m_off = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PhIdle; m_n <= 0; m_idx <= 0; m_count <= 0;
      m_s <= 0; m_k <= 0; m_off <= 0;
    end else begin
      case (m_phase)
        PhIdle: if (start) begin
          m_n     <= num_windows(int'(stride), int'(krows), int'(if_rows));
          m_s     <= (stride == 0) ? 1 : int'(stride);
          m_k     <= (krows == 0) ? 1 : ((int'(krows) > NUM_CH) ? NUM_CH : int'(krows));
          m_off   <= int'(offset);
          m_idx   <= 0;
          m_count <= 0;
          m_phase <= (num_windows(int'(stride), int'(krows), int'(if_rows)) == 0) ? PhDone
                                                                                   : PhRun;
        end
        PhRun: if (ready) begin
          m_count <= m_count + 1;
          if (m_idx == m_n - 1) m_phase <= PhDone;
          else m_idx <= m_idx + 1;
        end
        default: m_phase <= PhIdle;
      endcase
    end
  end

  // Compare process: DUT vs model on every falling edge.
  always @(negedge clk) begin
    bit ev;
    ev = (m_phase == PhRun);
    chk("busy", busy, m_phase != PhIdle);
    chk("valid", valid, ev);
    chk("done", done, m_phase == PhDone);
    chk("last", last, ev && (m_idx == m_n - 1));
    chk("win_count", win_count, m_count);
    chk("row_en", row_en, ev ? ((1 << m_k) - 1) : 0);
    if (ev) begin
      for (int i = 0; i < NUM_CH; i++)
        chk("row", row[i*W +: W], (m_idx * m_s + m_off + i) % (1 << W));
      if (first_row_en < 0) first_row_en = int'(row_en);
    end
    if (valid && ready) acc_q.push_back(int'(row[W-1:0]));
    if (done) done_cnt++;
  end

  function automatic logic ready_for(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 4 == 0) || (n % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_job(input int s, input int k, input int ifr, input int off, input int mode);
    int n;
    int done_before;
    acc_q.delete();
    first_row_en = -1;
    done_before = done_cnt;
    stride  = 4'(s);
    krows   = 4'(k);
    if_rows = W'(ifr);
    offset  = 4'(off);
    ready   = ready_for(mode, 0);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 3000) begin
      if (m_phase == PhIdle) break;
      ready   = ready_for(mode, n);
      // Config and Start changes mid-job must be ignored.
      stride  = 4'($urandom);
      krows   = 4'($urandom);
      offset  = 4'($urandom);
      if_rows = W'($urandom);
      start   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("job_terminates", m_phase == PhIdle, 1);
    chk("done_pulses", done_cnt - done_before, 1);
  endtask

  initial begin
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_row_en", row_en, 0);
    chk("reset_win_count", win_count, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release", busy, 0);

    // Basic run: 6 windows, bases 0..5.
    run_job(1, 3, 8, 0, 0);
    chk("s035_len", acc_q.size(), 6);
    for (int i = 0; i < 6; i++) if (i < acc_q.size()) chk("s035_row0", acc_q[i], i);
    chk("s035_count", win_count, 6);

    // Stride 2, offset 4: Row0 = 4, 6, 8, 10.
    run_job(2, 3, 10, 4, 0);
    chk("s036_len", acc_q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < acc_q.size()) chk("s036_row0", acc_q[i], 4 + 2 * i);
    chk("s036_count", win_count, 4);

    // Ready 1-0-0-1 stalls.
    run_job(1, 3, 8, 0, 1);
    chk("s037_len", acc_q.size(), 6);
    for (int i = 0; i < 6; i++) if (i < acc_q.size()) chk("s037_row0", acc_q[i], i);

    // K larger than the map: empty job.
    run_job(1, 5, 3, 0, 0);
    chk("s038_len", acc_q.size(), 0);
    chk("s038_count", win_count, 0);

    // Stride 0 and K 0 behave as 1.
    run_job(0, 0, 4, 0, 0);
    chk("s040_len", acc_q.size(), 4);
    chk("s040_row_en", first_row_en, 1);
    chk("s040_count", win_count, 4);

    // Reset during the third window.
    begin
      int n;
      int done_before;
      stride = 4'd1; krows = 4'd3; if_rows = W'(8); offset = 4'd0; ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (n < 20 && !(m_phase == PhRun && m_idx == 2)) begin
        @(posedge clk); #1;
        n++;
      end
      chk("s039_reached_third", m_idx, 2);
      done_before = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("s039_valid", valid, 0);
      chk("s039_busy", busy, 0);
      chk("s039_done", done, 0);
      chk("s039_last", last, 0);
      chk("s039_row_en", row_en, 0);
      chk("s039_count", win_count, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("s039_stays_idle", busy, 0);
      chk("s039_no_done", done_cnt - done_before, 0);
      run_job(1, 3, 8, 0, 0);
      chk("s039_rerun_len", acc_q.size(), 6);
      for (int i = 0; i < 6; i++) if (i < acc_q.size()) chk("s039_rerun_row0", acc_q[i], i);
    end

    // Row index wrap near the top of the index range.
    run_job(15, 3, 1023, 15, 2);
    chk("wrap_count", win_count, num_windows(15, 3, 1023));

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      int s, k, ifr, off, mode;
      s    = int'($urandom_range(0, 5));
      k    = int'($urandom_range(0, 7));
      ifr  = int'($urandom_range(0, 24));
      off  = int'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 2));
      run_job(s, k, ifr, off, mode);
      chk("rand_count", win_count, num_windows(s, k, ifr));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_row_seq.md
WINDOW_ROW_SEQ -- requirements
Module: WINDOW_ROW_SEQ

Interface
REQ-001 Parameter BITWIDTH_ROW, default 4, width of Offset and Kernel_Rows.
REQ-002 Parameter BITWIDTH_IF_ROWS, default 10, width of row indices, IF_Rows and Win_Count.
REQ-003 Parameter BITWIDTH_STRIDE, default 4, width of Stride.
REQ-004 Parameter NUM_CH, default 3, number of parallel row outputs (max kernel rows).
REQ-005 WINDOW_ROW_SEQ_clk  in  1  sole clock, rising edge.
REQ-006 WINDOW_ROW_SEQ_Clr  in  1  reset, asynchronous, active-low.
REQ-007 WINDOW_ROW_SEQ_Start  in  1  start pulse, sampled only in IDLE.
REQ-008 WINDOW_ROW_SEQ_Stride  in  BITWIDTH_STRIDE  row step per window.
REQ-009 WINDOW_ROW_SEQ_Offset  in  BITWIDTH_ROW  constant added to every row index.
REQ-010 WINDOW_ROW_SEQ_Kernel_Rows  in  BITWIDTH_ROW  active channels K, 1..NUM_CH.
REQ-011 WINDOW_ROW_SEQ_IF_Rows  in  BITWIDTH_IF_ROWS  input feature-map rows.
REQ-012 WINDOW_ROW_SEQ_Ready  in  1  downstream accepts current window.
REQ-013 WINDOW_ROW_SEQ_Row  out  NUM_CH*BITWIDTH_IF_ROWS  row indices, channel i at bits [i*W +: W].
REQ-014 WINDOW_ROW_SEQ_Row_En  out  NUM_CH  channel i valid when i<K.
REQ-015 WINDOW_ROW_SEQ_Valid  out  1  window presented.
REQ-016 WINDOW_ROW_SEQ_Last  out  1  current window is final one.
REQ-017 WINDOW_ROW_SEQ_Busy  out  1  high outside IDLE.
REQ-018 WINDOW_ROW_SEQ_Done  out  1  one-cycle completion pulse.
REQ-019 WINDOW_ROW_SEQ_Win_Count  out  BITWIDTH_IF_ROWS  windows accepted since Start.

Function
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on Start; RUN->DONE on accept of Last window; DONE->IDLE unconditionally next cycle.
REQ-021 On Start, Stride, Offset, Kernel_Rows, IF_Rows shall be latched; later input changes ignored until IDLE.
REQ-022 Latched Stride 0 shall be treated as 1; latched K 0 as 1; K>NUM_CH clamped to NUM_CH.
REQ-023 Internal base counter cleared on Start; Row[i] = base + Offset + i, modulo 2^BITWIDTH_IF_ROWS, combinational from registered base.
REQ-024 Valid high throughout RUN; accept = Valid & Ready; base += Stride and Win_Count += 1 on accept only.
REQ-025 Last = Valid & (base + Stride + K > IF_Rows), compared at BITWIDTH_IF_ROWS+1 bits (no wrap).
REQ-026 If K > IF_Rows at Start, RUN shall be skipped: IDLE->DONE, Valid never asserted, Win_Count 0.
REQ-027 Valid shall not drop while Ready low; Row shall hold stable while Valid & !Ready.
REQ-028 Start during RUN or DONE ignored; Start in same cycle as DONE->IDLE ignored.
REQ-029 Done high exactly one cycle in DONE; Win_Count held until next Start.
REQ-030 Row_En = (1<<K)-1 while Valid, else 0.

Reset
REQ-031 Clr low shall asynchronously force IDLE, base 0, Win_Count 0, Valid/Last/Done/Busy 0, Row_En 0, latched config 0.
REQ-032 Clr mid-RUN aborts with no Done pulse; first rising edge after release stays IDLE unless Start high.

Structure
REQ-033 FSM state encodings and default parameter values shall reside in shared package WINDOW_PKG.
REQ-034 Base register shall be one instance of sub-module STRIDE_ACC (async-low clear, enable, stride add, sync load-zero).

Verification
REQ-035 IF_Rows=8, K=3, Stride=1, Offset=0, Ready=1 -> 6 windows, bases 0..5, Last on base 5, Done, Win_Count=6.
REQ-036 IF_Rows=10, K=3, Stride=2, Offset=4 -> Row0 sequence 4,6,8,10; Last on 4th; Win_Count=4.
REQ-037 Ready toggled 1-0-0-1 per cycle -> Row/Valid stable during stalls, no window skipped or repeated.
REQ-038 K=5, IF_Rows=3 -> Busy 1 cycle, Done pulse, Valid never high, Win_Count=0.
REQ-039 Clr low during 3rd window -> all outputs 0 immediately, no Done; new Start runs full sequence from base 0.
REQ-040 Stride=0, K=0, IF_Rows=4 -> treated as Stride 1, K 1: 4 windows, Row_En=001.
